// File: rtl/dual_port_ram_pipe.sv
// Two-port RAM with fixed-latency, fully pipelined reads and writes, zeroed by an INIT sweep.
// Defining DPRAM_COLLISION_FLAG_EN adds the `collision` output for same-address dual commits.
module dual_port_ram_pipe #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 3,
  parameter int READ_LATENCY  = 3,
  parameter int WRITE_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_ready,
  output logic                  b_ready,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
`ifdef DPRAM_COLLISION_FLAG_EN
  output logic                  collision,
`endif
  output logic [0:0]            dbg_state_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  run;

  // Handshake: a request is taken in any cycle where req & ready; ready is
  // high for the whole RUN state, so there is never back-pressure there.
  assign run         = (state_q == ST_RUN);
  assign a_ready     = run;
  assign b_ready     = run;
  assign dbg_state_o = state_q;

  // Index 0 is port A, index 1 is port B.
  logic [1:0]            req, we, rd_acc, wr_acc;
  logic [ADDR_WIDTH-1:0] addr  [2];
  logic [DATA_WIDTH-1:0] wdata [2];

  always_comb begin
    req      = {b_req, a_req};
    we       = {b_we, a_we};
    addr[0]  = a_addr;
    addr[1]  = b_addr;
    wdata[0] = a_wdata;
    wdata[1] = b_wdata;
    rd_acc   = req & ~we & {2{run}};
    wr_acc   = req &  we & {2{run}};
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
      if (init_cnt_q == LAST_ADDR) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Read pipeline: stage 0 captures the array in the accept cycle, the last
  // stage is the output. Data stages only load on valid so rdata holds.
  logic [READ_LATENCY-1:0] rv_q  [2];
  logic [DATA_WIDTH-1:0]   rd_q  [2][READ_LATENCY];
  logic [READ_LATENCY-1:0] rv_in [2];
  logic [DATA_WIDTH-1:0]   rd_in [2][READ_LATENCY];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rv_in[p]    = '0;
      rv_in[p][0] = rd_acc[p];
      rd_in[p][0] = mem_q[addr[p]];
      for (int s = 1; s < READ_LATENCY; s++) begin
        rv_in[p][s] = rv_q[p][s-1];
        rd_in[p][s] = rd_q[p][s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        rv_q[p] <= '0;
        for (int s = 0; s < READ_LATENCY; s++) rd_q[p][s] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        for (int s = 0; s < READ_LATENCY; s++) begin
          rv_q[p][s] <= rv_in[p][s];
          if (rv_in[p][s]) rd_q[p][s] <= rd_in[p][s];
        end
      end
    end
  end

  assign a_rvalid = rv_q[0][READ_LATENCY-1];
  assign b_rvalid = rv_q[1][READ_LATENCY-1];
  assign a_rdata  = rd_q[0][READ_LATENCY-1];
  assign b_rdata  = rd_q[1][READ_LATENCY-1];

  // Write path: WRITE_LATENCY-1 register stages, commit from the last one.
  logic [1:0]            wc_v;
  logic [ADDR_WIDTH-1:0] wc_addr [2];
  logic [DATA_WIDTH-1:0] wc_data [2];

  generate
    if (WRITE_LATENCY == 1) begin : g_wr_direct
      always_comb begin
        wc_v = wr_acc;
        for (int p = 0; p < 2; p++) begin
          wc_addr[p] = addr[p];
          wc_data[p] = wdata[p];
        end
      end
    end else begin : g_wr_pipe
      localparam int WS = WRITE_LATENCY - 1;
      logic [WS-1:0]         wv_q [2];
      logic [ADDR_WIDTH-1:0] wa_q [2][WS];
      logic [DATA_WIDTH-1:0] wd_q [2][WS];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int p = 0; p < 2; p++) begin
            wv_q[p] <= '0;
            for (int s = 0; s < WS; s++) begin
              wa_q[p][s] <= '0;
              wd_q[p][s] <= '0;
            end
          end
        end else begin
          for (int p = 0; p < 2; p++) begin
            wv_q[p][0] <= wr_acc[p];
            wa_q[p][0] <= addr[p];
            wd_q[p][0] <= wdata[p];
            for (int s = 1; s < WS; s++) begin
              wv_q[p][s] <= wv_q[p][s-1];
              wa_q[p][s] <= wa_q[p][s-1];
              wd_q[p][s] <= wd_q[p][s-1];
            end
          end
        end
      end

      always_comb begin
        for (int p = 0; p < 2; p++) begin
          wc_v[p]    = wv_q[p][WS-1];
          wc_addr[p] = wa_q[p][WS-1];
          wc_data[p] = wd_q[p][WS-1];
        end
      end
    end
  endgenerate

  // Port B is written first so port A's value lands on a same-address commit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem_q[init_cnt_q] <= '0;
      end else begin
        if (wc_v[1]) mem_q[wc_addr[1]] <= wc_data[1];
        if (wc_v[0]) mem_q[wc_addr[0]] <= wc_data[0];
      end
    end
  end

`ifdef DPRAM_COLLISION_FLAG_EN
  assign collision = run & wc_v[0] & wc_v[1] & (wc_addr[0] == wc_addr[1]);
`endif

endmodule

// File: tb/tb_dual_port_ram_pipe.sv
// Directed bench for dual_port_ram_pipe with a cycle-level behavioural model and literal pins.
module tb_dual_port_ram_pipe;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int RL    = 3;
  localparam int WL    = 3;
  localparam int DEPTH = 8;

  typedef struct {
    int            commit;
    int            port;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int            cyc;
    int            port;
    logic [DW-1:0] data;
  } pin_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ready, b_ready, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [0:0]    dbg_state_o;
`ifdef DPRAM_COLLISION_FLAG_EN
  logic          collision;
`endif

  always #5 clk = ~clk;

  dual_port_ram_pipe #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_ready(a_ready), .b_ready(b_ready),
    .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
`ifdef DPRAM_COLLISION_FLAG_EN
    .collision(collision),
`endif
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard state ----------------
  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc   = 0;
  bit            live  = 1'b0;
  int            init_left;
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] exp_q_a[$], exp_q_b[$];
  int            due_a[$], due_b[$];
  wr_t           pend_q[$];
  pin_t          pin_q[$];
  logic [DW-1:0] last_a, last_b, ed_a, ed_b;
  bit            ev_a, ev_b, exp_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Checker/model: runs at every falling edge, i.e. mid-cycle.
  always @(negedge clk) begin
    if (live) begin
      exp_ready = (init_left == 0);
      chk("a_ready", 32'(a_ready), 32'(exp_ready));
      chk("b_ready", 32'(b_ready), 32'(exp_ready));
      chk("dbg_state", 32'(dbg_state_o), 32'(exp_ready));
      ev_a = 1'b0;
      ed_a = last_a;
      if (due_a.size() > 0) if (due_a[0] == cyc) begin ev_a = 1'b1; ed_a = exp_q_a[0]; end
      ev_b = 1'b0;
      ed_b = last_b;
      if (due_b.size() > 0) if (due_b[0] == cyc) begin ev_b = 1'b1; ed_b = exp_q_b[0]; end
      chk("a_rvalid", 32'(a_rvalid), 32'(ev_a));
      chk("a_rdata", 32'(a_rdata), 32'(ed_a));
      chk("b_rvalid", 32'(b_rvalid), 32'(ev_b));
      chk("b_rdata", 32'(b_rdata), 32'(ed_b));
      for (int i = pin_q.size() - 1; i >= 0; i--) begin
        if (pin_q[i].cyc == cyc) begin
          if (pin_q[i].port == 0) begin
            chk("pin_a_rvalid", 32'(a_rvalid), 32'd1);
            chk("pin_a_rdata", 32'(a_rdata), 32'(pin_q[i].data));
            chk("pin_model_a", ev_a ? 32'(ed_a) : 32'hDEAD, 32'(pin_q[i].data));
          end else begin
            chk("pin_b_rvalid", 32'(b_rvalid), 32'd1);
            chk("pin_b_rdata", 32'(b_rdata), 32'(pin_q[i].data));
            chk("pin_model_b", ev_b ? 32'(ed_b) : 32'hDEAD, 32'(pin_q[i].data));
          end
          pin_q.delete(i);
        end
      end
      if (ev_a) begin last_a = ed_a; void'(exp_q_a.pop_front()); void'(due_a.pop_front()); end
      if (ev_b) begin last_b = ed_b; void'(exp_q_b.pop_front()); void'(due_b.pop_front()); end
    end

    if (rst) begin
      live = 1'b1;
      init_left = DEPTH;
      exp_q_a.delete(); exp_q_b.delete(); due_a.delete(); due_b.delete();
      pend_q.delete();
      last_a = '0;
      last_b = '0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    end else if (live) begin
      if (init_left == 0) begin
        if (a_req) begin
          if (a_we) pend_q.push_back('{cyc + WL - 1, 0, a_addr, a_wdata});
          else begin exp_q_a.push_back(mem_m[a_addr]); due_a.push_back(cyc + RL); end
        end
        if (b_req) begin
          if (b_we) pend_q.push_back('{cyc + WL - 1, 1, b_addr, b_wdata});
          else begin exp_q_b.push_back(mem_m[b_addr]); due_b.push_back(cyc + RL); end
        end
      end
      begin : commits
        bit            ca, cb;
        logic [AW-1:0] aa, ba;
        ca = 1'b0; cb = 1'b0; aa = '0; ba = '0;
        foreach (pend_q[i]) if (pend_q[i].commit == cyc && pend_q[i].port == 1) begin
          mem_m[pend_q[i].addr] = pend_q[i].data; cb = 1'b1; ba = pend_q[i].addr;
        end
        foreach (pend_q[i]) if (pend_q[i].commit == cyc && pend_q[i].port == 0) begin
          mem_m[pend_q[i].addr] = pend_q[i].data; ca = 1'b1; aa = pend_q[i].addr;
        end
`ifdef DPRAM_COLLISION_FLAG_EN
        chk("collision", 32'(collision), 32'(ca && cb && aa == ba));
`endif
        if (ca && cb && aa == ba) begin end
        for (int i = pend_q.size() - 1; i >= 0; i--)
          if (pend_q[i].commit == cyc) pend_q.delete(i);
      end
      if (init_left > 0) init_left--;
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic drive_a(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = data;
  endtask

  task automatic drive_b(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = data;
  endtask

  task automatic add_pin(input int at, input int port, input logic [DW-1:0] data);
    pin_q.push_back('{at, port, data});
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!a_ready && n < 40) begin
      tick();
      n++;
    end
    chk(name, 32'(n), 32'd8);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_rdata_a", 32'(a_rdata), 32'd0);
    chk("reset_rvalid_b", 32'(b_rvalid), 32'd0);
    wait_ready("init_ready_cycles");

    // Every location reads back zero after the INIT sweep.
    for (int i = 0; i < DEPTH; i++) begin
      drive_a(1'b0, AW'(i), '0);
      drive_b(1'b0, AW'(DEPTH - 1 - i), '0);
      add_pin(cyc + RL, 0, 8'h00);
      add_pin(cyc + RL, 1, 8'h00);
      tick();
    end
    repeat (RL + 2) tick();

    // Write latency: read two cycles after the write sees old data, three after sees new.
    drive_a(1'b1, 3'd2, 8'hA5);
    tick();
    tick();
    drive_b(1'b0, 3'd2, '0);
    add_pin(cyc + RL, 1, 8'h00);
    tick();
    drive_b(1'b0, 3'd2, '0);
    add_pin(cyc + RL, 1, 8'hA5);
    tick();
    repeat (RL + 2) tick();

    // Same-address dual write: port A wins; both ports then read the same value.
    drive_a(1'b1, 3'd5, 8'h11);
    drive_b(1'b1, 3'd5, 8'h22);
    tick();
    repeat (WL) tick();
    drive_a(1'b0, 3'd5, '0);
    drive_b(1'b0, 3'd5, '0);
    add_pin(cyc + RL, 0, 8'h11);
    add_pin(cyc + RL, 1, 8'h11);
    tick();
    repeat (RL + 2) tick();

    // Fill 0x10..0x17, then back-to-back reads on port A.
    for (int i = 0; i < DEPTH; i++) begin
      drive_b(1'b1, AW'(i), DW'(16 + i));
      tick();
    end
    repeat (WL) tick();
    for (int i = 0; i < DEPTH; i++) begin
      drive_a(1'b0, AW'(i), '0);
      drive_b(1'b0, AW'(DEPTH - 1 - i), '0);
      add_pin(cyc + RL, 0, DW'(16 + i));
      tick();
    end
    repeat (RL + 2) tick();

    // Mixed traffic on both ports, checked against the model only.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0)
        drive_a(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) != 0)
        drive_b(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom_range(0, 255)));
      tick();
    end
    repeat (RL + 2) tick();

    // Reset with a write and a read in flight: neither survives.
    drive_a(1'b1, 3'd1, 8'hFF);
    drive_b(1'b0, 3'd1, '0);
    tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    wait_ready("reinit_ready_cycles");
    drive_a(1'b0, 3'd1, '0);
    add_pin(cyc + RL, 0, 8'h00);
    tick();
    repeat (RL + 3) tick();

    chk("pins_consumed", 32'(pin_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_pipe.md
DUAL_PORT_RAM_PIPE -- requirements
Module: dual_port_ram_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, address width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter READ_LATENCY, default 3, accept-to-rvalid cycles, legal range >=1.
REQ-004 SHALL have parameter WRITE_LATENCY, default 3, accept-to-commit cycles, legal range >=1.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have ports a_req/b_req  input  1  request valid per port.
REQ-008 SHALL have ports a_we/b_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have ports a_addr/b_addr  input  ADDR_WIDTH  word address.
REQ-010 SHALL have ports a_wdata/b_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have ports a_ready/b_ready  output  1  request accepted when req & ready.
REQ-012 SHALL have ports a_rvalid/b_rvalid  output  1  one-cycle read-return strobe.
REQ-013 SHALL have ports a_rdata/b_rdata  output  DATA_WIDTH  read data, meaningful only with rvalid.

Function
REQ-014 SHALL implement FSM with states INIT and RUN; reset enters INIT.
REQ-015 In INIT, SHALL write zero to one address per cycle, addresses 0..depth-1 ascending, then enter RUN; INIT lasts exactly depth cycles.
REQ-016 SHALL drive a_ready = b_ready = 0 in INIT and 1 in RUN; requests during INIT are dropped, never returning rvalid.
REQ-017 Read accepted in cycle T SHALL sample the array in cycle T and present rvalid=1 with data in cycle T+READ_LATENCY, exactly one cycle.
REQ-018 Write accepted in cycle T SHALL update the array at the clock edge closing cycle T+WRITE_LATENCY-1; reads accepted in cycle T+WRITE_LATENCY or later see the new value.
REQ-019 Both ports SHALL accept one request per cycle each, fully pipelined, no back-pressure in RUN.
REQ-020 Read sampling an address whose write commits in the same cycle SHALL return the old value (read-before-write).
REQ-021 Writes from both ports committing to the same address in the same cycle: port A data SHALL win.
REQ-022 Simultaneous reads of the same address on both ports SHALL both return the same data.
REQ-023 Addresses SHALL not wrap or saturate; every ADDR_WIDTH value is a valid location.
REQ-024 rdata SHALL hold its last value when rvalid=0.

Reset
REQ-025 rst sampled high SHALL, on that edge, clear read and write pipelines, drive rvalid=0, rdata=0, ready=0, and restart INIT at address 0.
REQ-026 Reset mid-operation SHALL discard all in-flight writes (not committed) and in-flight reads (no rvalid).
REQ-027 Reset held for several cycles SHALL keep INIT counter at 0; sweep starts in the first cycle rst is low.

Configuration
REQ-028 Macro DPRAM_COLLISION_FLAG_EN, when defined, SHALL add output collision (1 bit, reset 0), pulsing 1 for one cycle in any cycle where both ports commit writes to the same address.
REQ-029 Without DPRAM_COLLISION_FLAG_EN, port collision SHALL not exist; all other behaviour is identical.

Verification
REQ-030 Init: deassert rst, depth 8 -> ready low 8 cycles, then high; read all 8 addresses -> all return 0x00.
REQ-031 Latency: port A write addr 2 = 0xA5 at T, port B read addr 2 at T+2 -> 0x00 at T+5; read at T+3 -> 0xA5 at T+6.
REQ-032 Collision: A writes 0x11, B writes 0x22 to addr 5 same cycle -> later read returns 0x11; collision pulses once when macro defined.
REQ-033 Back-to-back: A reads addrs 0..7 on consecutive cycles after filling 0x10..0x17 -> 8 consecutive rvalid cycles, data 0x10..0x17 in order.
REQ-034 Mid-flight reset: issue write addr 1 = 0xFF and read addr 1, assert rst next cycle -> no rvalid, after INIT addr 1 reads 0x00.
